// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select generator and load-use hazard detector built on an EX/MEM/WB
// destination-tag pipeline. Optional performance counters are enabled by FWD_PERF_CNT_EN.
module forward_hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              mem_busy,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              freeze,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  fwd_count
);

  localparam logic [1:0] SEL_IDEX  = 2'd0;
  localparam logic [1:0] SEL_WB    = 2'd1;
  localparam logic [1:0] SEL_EXMEM = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              reg_write;
    logic              mem_read;
  } tag_t;

  localparam tag_t TAG_EMPTY = '0;

  tag_t ex_tag_reg;
  tag_t mem_tag_reg;
  tag_t wb_tag_reg;
  tag_t id_tag;
  logic load_use;
  logic [1:0][ADDR_W-1:0] src;

  assign id_tag = '{valid: id_valid, dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read};
  assign src    = {id_rt, id_rs};

  // A load still in EX cannot supply its data yet: hold ID for one cycle.
  always_comb begin
    load_use = 1'b0;
    if (id_valid && ex_tag_reg.valid && ex_tag_reg.mem_read && ex_tag_reg.reg_write &&
        ex_tag_reg.dest != '0)
      load_use = (ex_tag_reg.dest == id_rs) || (ex_tag_reg.dest == id_rt);
  end

  assign stall  = load_use & ~mem_busy;
  assign freeze = mem_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag_reg  <= TAG_EMPTY;
      mem_tag_reg <= TAG_EMPTY;
      wb_tag_reg  <= TAG_EMPTY;
    end else if (!mem_busy) begin
      ex_tag_reg  <= load_use ? TAG_EMPTY : id_tag;
      mem_tag_reg <= ex_tag_reg;
      wb_tag_reg  <= mem_tag_reg;
    end
  end

  // The WB tag only marks the retiring slot; forwarding never looks at it.
  logic unused_wb;
  assign unused_wb = ^wb_tag_reg;

  // One select per source operand: the EX producer (next in MEM) beats the MEM producer.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic       hit_ex;
    logic       hit_mem;
    logic [1:0] sel_next;
    logic [1:0] sel_reg;

    assign hit_ex  = ex_tag_reg.valid && ex_tag_reg.reg_write &&
                     (ex_tag_reg.dest == src[gi]) && (src[gi] != '0);
    assign hit_mem = mem_tag_reg.valid && mem_tag_reg.reg_write &&
                     (mem_tag_reg.dest == src[gi]) && (src[gi] != '0);

    always_comb begin
      sel_next = SEL_IDEX;
      if (id_valid) begin
        if (hit_ex)
          sel_next = SEL_EXMEM;
        else if (hit_mem)
          sel_next = SEL_WB;
      end
    end

    always_ff @(posedge clk) begin
      if (rst)
        sel_reg <= SEL_IDEX;
      else if (!mem_busy)
        sel_reg <= load_use ? SEL_IDEX : sel_next;
    end
  end

  assign forward_a = g_src[0].sel_reg;
  assign forward_b = g_src[1].sel_reg;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_count_reg;
  logic [CNT_W-1:0] fwd_count_reg;
  logic [1:0]       fwd_inc;

  assign fwd_inc = 2'(g_src[0].sel_next != SEL_IDEX) + 2'(g_src[1].sel_next != SEL_IDEX);

  // A stall cycle registers zero selects, so the two counters never step together.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_reg <= '0;
      fwd_count_reg   <= '0;
    end else if (!mem_busy) begin
      if (load_use)
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      else
        fwd_count_reg <= fwd_count_reg + CNT_W'(fwd_inc);
    end
  end

  assign stall_count = stall_count_reg;
  assign fwd_count   = fwd_count_reg;
`else
  assign stall_count = '0;
  assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed + random stimulus for forward_hazard_unit, checked against an
// instruction-history model of the pipeline.
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_dest;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        mem_busy;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall;
  logic        freeze;
  logic [31:0] stall_count;
  logic [31:0] fwd_count;

  always #5 clk = ~clk;

  forward_hazard_unit #(.ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_busy(mem_busy), .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .freeze(freeze), .stall_count(stall_count), .fwd_count(fwd_count)
  );

  // History of what entered EX, youngest first: [0] is now in EX, [1] in MEM.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
  } rec_t;

  rec_t        hist[$];
  logic [1:0]  m_fa, m_fb;
  int unsigned m_stall_cnt, m_fwd_cnt;
  int          errors = 0;
  int          checks = 0;
  logic        obs_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_front(rec_t'(0));
    m_fa = 2'd0;
    m_fb = 2'd0;
    m_stall_cnt = 0;
    m_fwd_cnt = 0;
  endtask

  // Nearest earlier producer of s decides: one slot back -> 2, two slots back -> 1.
  function automatic logic [1:0] exp_sel(input logic [4:0] s);
    if (s == 5'd0) return 2'd0;
    for (int d = 0; d < 2; d++)
      if (hist[d].valid && hist[d].rw && hist[d].dest == s) return 2'(2 - d);
    return 2'd0;
  endfunction

  task automatic step(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] dest, input logic rw, input logic mr, input logic mb);
    logic es;
    logic [1:0] sa, sb;
    @(negedge clk);
    check("fwd_a", {30'd0, forward_a}, {30'd0, m_fa});
    check("fwd_b", {30'd0, forward_b}, {30'd0, m_fb});
`ifdef FWD_PERF_CNT_EN
    check("stall_count", stall_count, m_stall_cnt);
    check("fwd_count", fwd_count, m_fwd_cnt);
`else
    check("stall_count", stall_count, 32'd0);
    check("fwd_count", fwd_count, 32'd0);
`endif
    rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_dest = dest;
    id_reg_write = rw; id_mem_read = mr; mem_busy = mb;
    #1;
    es = v && hist[0].valid && hist[0].mr && hist[0].rw && hist[0].dest != 5'd0 &&
         (hist[0].dest == rs || hist[0].dest == rt) && !mb;
    obs_stall = stall;
    check("stall", {31'd0, stall}, {31'd0, es});
    check("freeze", {31'd0, freeze}, {31'd0, mb});
    sa = v ? exp_sel(rs) : 2'd0;
    sb = v ? exp_sel(rt) : 2'd0;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (!mb) begin
      if (es) begin
        hist.push_front(rec_t'(0));
        m_fa = 2'd0;
        m_fb = 2'd0;
        m_stall_cnt++;
      end else begin
        hist.push_front('{valid: v, dest: dest, rw: rw, mr: mr});
        m_fa = sa;
        m_fb = sb;
        m_fwd_cnt += 32'(sa != 2'd0) + 32'(sb != 2'd0);
      end
      void'(hist.pop_back());
    end
    $display("t=%0t rst=%0b v=%0b rs=%0d rt=%0d dest=%0d rw=%0b mr=%0b busy=%0b -> stall=%0b fa=%0d fb=%0d",
             $time, r, v, rs, rt, dest, rw, mr, mb, obs_stall, m_fa, m_fb);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; mem_busy = 1'b0;
    model_reset();

    // Reset, then confirm cleared state.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    #2; check("reset_fa", {30'd0, forward_a}, 32'd0);

    // add $3; sub rs=$3 -> forward_a=2.
    step(0, 1, 1, 2, 3, 1, 0, 0);
    step(0, 1, 3, 4, 6, 1, 0, 0);
    #2; check("add_sub_fa", {30'd0, forward_a}, 32'd2);
    check("add_sub_fb", {30'd0, forward_b}, 32'd0);
    check("add_sub_stall", {31'd0, obs_stall}, 32'd0);

    // add $3; nop; sub rt=$3 -> forward_b=1.
    step(0, 1, 1, 2, 3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 7, 1, 0, 0);
    #2; check("gap_fb", {30'd0, forward_b}, 32'd1);

    // lw $3; add rs=$3 -> one stall, then forward_a=1.
    step(0, 1, 1, 2, 3, 1, 1, 0);
    step(0, 1, 3, 0, 8, 1, 0, 0);
    check("lw_stall", {31'd0, obs_stall}, 32'd1);
    #2; check("lw_bubble_fa", {30'd0, forward_a}, 32'd0);
    step(0, 1, 3, 0, 8, 1, 0, 0);
    check("lw_resume_stall", {31'd0, obs_stall}, 32'd0);
    #2; check("lw_resume_fa", {30'd0, forward_a}, 32'd1);

    // Two producers of $5, consumer rs=rt=$5 -> both selects 2.
    step(0, 1, 1, 2, 5, 1, 0, 0);
    step(0, 1, 1, 2, 5, 1, 0, 0);
    step(0, 1, 5, 5, 9, 1, 0, 0);
    #2; check("dual_fa", {30'd0, forward_a}, 32'd2);
    check("dual_fb", {30'd0, forward_b}, 32'd2);

    // Register 0 never forwards or stalls.
    step(0, 1, 1, 2, 0, 1, 0, 0);
    step(0, 1, 0, 0, 9, 1, 0, 0);
    #2; check("r0_fa", {30'd0, forward_a}, 32'd0);
    step(0, 1, 1, 2, 0, 1, 1, 0);
    step(0, 1, 0, 0, 9, 1, 0, 0);
    check("r0_lw_stall", {31'd0, obs_stall}, 32'd0);

    // Load-use under a 3-cycle freeze, then a single stall.
    step(0, 1, 1, 2, 3, 1, 1, 0);
    repeat (3) begin
      step(0, 1, 3, 0, 8, 1, 0, 1);
      check("frozen_stall", {31'd0, obs_stall}, 32'd0);
    end
    step(0, 1, 3, 0, 8, 1, 0, 0);
    check("unfrozen_stall", {31'd0, obs_stall}, 32'd1);
    step(0, 1, 3, 0, 8, 1, 0, 0);
    check("post_stall", {31'd0, obs_stall}, 32'd0);
    #2; check("post_stall_fa", {30'd0, forward_a}, 32'd1);

    // Reset during a stall cycle.
    step(0, 1, 1, 2, 3, 1, 1, 0);
    step(1, 1, 3, 0, 8, 1, 0, 0);
    check("rst_mid_stall_in", {31'd0, obs_stall}, 32'd1);
    step(0, 1, 3, 3, 8, 1, 0, 0);
    check("rst_after_stall", {31'd0, obs_stall}, 32'd0);
    #2; check("rst_after_fa", {30'd0, forward_a}, 32'd0);

    // Back-to-back dependent loads.
    step(0, 1, 1, 2, 3, 1, 1, 0);
    step(0, 1, 3, 0, 4, 1, 1, 0);
    check("b2b_stall1", {31'd0, obs_stall}, 32'd1);
    step(0, 1, 3, 0, 4, 1, 1, 0);
    step(0, 1, 4, 0, 6, 1, 0, 0);
    check("b2b_stall2", {31'd0, obs_stall}, 32'd1);
    step(0, 1, 4, 0, 6, 1, 0, 0);
    check("b2b_done", {31'd0, obs_stall}, 32'd0);

    // Random traffic over a small register range to provoke hazards.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) == 0));
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Pipeline control block that produces the 2-bit operand-forwarding selects consumed by the EX-stage forwarding muxes, and detects load-use hazards. It tracks the destination tags of in-flight instructions in an internal EX/MEM/WB tag pipeline. It computes each decode-stage instruction's forwarding selects one cycle ahead and registers them so they are valid while that instruction is in EX. It sits beside the ID/EX pipeline register and drives the PC/IF-ID hold and the bubble insertion.

## Interface
Parameters:
- ADDR_W, 5, register-address width
- CNT_W, 32, performance-counter width (used only with FWD_PERF_CNT_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  decode-stage slot holds a real instruction
- id_rs  in  ADDR_W  source register A of the decode-stage instruction
- id_rt  in  ADDR_W  source register B of the decode-stage instruction
- id_dest  in  ADDR_W  destination register of the decode-stage instruction
- id_reg_write  in  1  decode-stage instruction writes id_dest
- id_mem_read  in  1  decode-stage instruction is a load
- mem_busy  in  1  memory not ready; freeze the whole pipeline
- forward_a  out  2  select for operand A of the EX-stage instruction
- forward_b  out  2  select for operand B of the EX-stage instruction
- stall  out  1  load-use stall: hold PC and IF/ID, insert bubble into ID/EX
- freeze  out  1  equals mem_busy; all pipeline registers hold
- stall_count  out  CNT_W  load-use stall cycles (FWD_PERF_CNT_EN only)
- fwd_count  out  CNT_W  operands forwarded (FWD_PERF_CNT_EN only)

## Operation
- Select encoding is fixed and matches the forwarding mux:
  - 0 = ID/EX register value
  - 1 = WB data
  - 2 = EXE/MEM result
  - 3 is never driven.
- Tag pipeline has three stages, EX, MEM and WB. Each stage holds {valid, dest, reg_write, mem_read}.
- On an advance cycle (no freeze, no stall):
  - EX ← ID inputs, with valid = id_valid.
  - MEM ← EX.
  - WB ← MEM.
- Stall cycle (no freeze):
  - EX ← bubble (valid=0, reg_write=0, mem_read=0).
  - MEM ← EX and WB ← MEM as normal.
  - forward_a/b ← 0.
- Freeze cycle: tags, forward_a/b and counters all hold.
- Next-cycle select for source s ∈ {id_rs, id_rt}, evaluated combinationally and registered on advance:
  - 2 if EX.valid & EX.reg_write & EX.dest == s & s ≠ 0;
  - else 1 if MEM.valid & MEM.reg_write & MEM.dest == s & s ≠ 0;
  - else 0.
  - Rule: EX tag → future MEM stage → code 2; MEM tag → future WB stage → code 1. The younger producer wins.
  - If id_valid=0, the registered selects are 0.
- stall = id_valid & EX.valid & EX.mem_read & EX.reg_write & EX.dest ≠ 0 & (EX.dest == id_rs | EX.dest == id_rt), gated low while mem_busy.
- A load in EX therefore never yields code 2. After the single stall cycle the load sits in MEM, and the re-evaluated select is 1.
- Register 0 never forwards and never stalls.

## Timing
- Reset (sync, rst high at clock edge): all tag valid bits 0, forward_a=forward_b=0, counters 0.
  - stall is combinational from the cleared tags, so it reads 0 in the cycle after reset.
- Select latency: computed during the instruction's ID cycle, valid for exactly its EX cycle (one-cycle registered latency).
- stall is combinational and asserted in the same cycle the dependent instruction is in ID. It lasts exactly one cycle per load-use pair unless frozen.
- Simultaneous events:
  - mem_busy has priority over stall; stall output reads 0 while frozen.
  - The stall resumes evaluation on the first unfrozen cycle.
- rst mid-stall: the next cycle has stall=0, the tags are empty and the selects are 0.
- Back-to-back dependent loads each incur one stall.

## Configuration
- FWD_PERF_CNT_EN defined:
  - stall_count increments on each cycle with stall=1.
  - fwd_count increments by the number of nonzero selects registered that cycle (0, 1 or 2).
  - Both counters wrap modulo 2^CNT_W and hold during freeze.
- Undefined: counter registers are not built and stall_count/fwd_count are tied to 0.

## Test plan
- add $3 ← …, then sub using rs=$3 in the next slot -> forward_a=2 in sub's EX cycle, forward_b=0, stall=0.
- add $3, nop, sub rt=$3 -> forward_b=1 in sub's EX cycle.
- lw $3, then add rs=$3 -> stall=1 for one cycle with a bubble in EX; next cycle forward_a=1 in add's EX cycle; stall_count=1 with FWD_PERF_CNT_EN.
- Producers to $5 in both EX and MEM tags, consumer rs=rt=$5 -> forward_a=forward_b=2; with the macro, fwd_count += 2.
- Producer with id_dest=0, id_reg_write=1, consumer rs=0 -> forward_a=0, stall=0.
- lw $3 / add $3 with mem_busy asserted for 3 cycles during the stall, then rst mid-sequence:
  - while frozen, all outputs hold and stall=0;
  - after release, exactly one stall cycle occurs;
  - after rst, the outputs are 0 and the tags are empty.
